// File: rtl/fetch_pkg.sv
// Shared types and constants for the KGP-RISC fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned FETCH_CNT_W  = 32;
  localparam int unsigned SQUASH_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    OUT      = 2'd2,
    REDIRECT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Free-running fetch and squash event counters; both wrap on overflow.
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_inc_i,
  input  logic                    squash_inc_i,
  output logic [FETCH_CNT_W-1:0]  fetch_cnt_o,
  output logic [SQUASH_CNT_W-1:0] squash_cnt_o
);

  logic [FETCH_CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic [SQUASH_CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + FETCH_CNT_W'(fetch_inc_i);
    squash_cnt_d = squash_cnt_q + SQUASH_CNT_W'(squash_inc_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign squash_cnt_o = squash_cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC advance/branch control, imem handshake, one-entry decode slot.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt / squash_cnt counter outputs.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [XLEN-1:0]         pc_in,
  output logic                    pc_adv,
  output logic                    take_branch,
  output logic                    imem_req,
  output logic [XLEN-1:0]         imem_addr,
  input  logic                    imem_ack,
  input  logic [XLEN-1:0]         imem_rdata,
  output logic                    instr_valid,
  output logic [XLEN-1:0]         instr,
  output logic [XLEN-1:0]         instr_pc,
  input  logic                    dec_ready,
  input  logic                    br_req,
  output logic                    br_ack,
`ifdef FETCH_PERF_CNT_EN
  output logic [FETCH_CNT_W-1:0]  fetch_cnt,
  output logic [SQUASH_CNT_W-1:0] squash_cnt,
`endif
  output logic                    misalign
);

  fetch_state_e    state_q, state_d;
  logic            br_pend_q, br_pend_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      br_pend_q  <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      br_pend_q  <= br_pend_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    br_pend_d   = br_pend_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    pc_adv      = 1'b0;
    take_branch = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = '0;
    instr_valid = 1'b0;
    br_ack      = 1'b0;
    misalign    = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_in;
        misalign  = |pc_in[1:0];
        if (br_req) br_pend_d = 1'b1;
        // A branch seen at any point of the fetch makes the returned word wrong-path.
        if (imem_ack) begin
          if (br_pend_q || br_req) begin
            state_d = REDIRECT;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_in;
            state_d    = OUT;
          end
        end
      end
      OUT: begin
        instr_valid = 1'b1;
        if (br_req) begin
          state_d = REDIRECT;
        end else if (dec_ready) begin
          pc_adv  = 1'b1;
          state_d = FETCH;
        end
      end
      REDIRECT: begin
        pc_adv      = 1'b1;
        take_branch = 1'b1;
        br_ack      = 1'b1;
        br_pend_d   = 1'b0;
        state_d     = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr    = instr_q;
  assign instr_pc = instr_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc_c;
  logic squash_inc_c;

  assign fetch_inc_c  = (state_q == FETCH) && imem_ack;
  assign squash_inc_c = (fetch_inc_c && (br_pend_q || br_req)) ||
                        ((state_q == OUT) && br_req);

  fetch_perf_cnt u_perf_cnt (
    .clk          (clk),
    .rst          (rst),
    .fetch_inc_i  (fetch_inc_c),
    .squash_inc_i (squash_inc_c),
    .fetch_cnt_o  (fetch_cnt),
    .squash_cnt_o (squash_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized self-checking bench for fetch_ctrl against an activity-level reference model.
module tb_fetch_ctrl;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_in;
  logic            pc_adv, take_branch, imem_req, imem_ack;
  logic [XLEN-1:0] imem_addr, imem_rdata, instr, instr_pc;
  logic            instr_valid, dec_ready, br_req, br_ack, misalign;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     fetch_cnt;
  logic [15:0]     squash_cnt;
`endif

  fetch_ctrl #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_adv      (pc_adv),
    .take_branch (take_branch),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .dec_ready   (dec_ready),
    .br_req      (br_req),
    .br_ack      (br_ack),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt   (fetch_cnt),
    .squash_cnt  (squash_cnt),
`endif
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the sequencer is busy with this cycle.
  bit          m_boot, m_fetch, m_full, m_redir, m_pend;
  logic [31:0] m_instr, m_ipc;
  logic [31:0] m_fetched;
  logic [15:0] m_squashed;

  // Environment: PC register, memory latency and branch source.
  logic [31:0] pc_m, br_off;
  bit          mem_busy, br_drop;
  int          mem_left;

  task automatic model_reset();
    m_boot = 1; m_fetch = 0; m_full = 0; m_redir = 0; m_pend = 0;
    m_instr = '0; m_ipc = '0; m_fetched = '0; m_squashed = '0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic do_cycle(input int wait_sel, input int dec_pct, input int br_pct,
                          input bit fixed, input logic [31:0] data);
    bit          exp_adv;
    logic [31:0] pc_old;
    pc_in      = pc_m;
    dec_ready  = ($urandom_range(0, 99) < dec_pct);
    if (br_drop) begin
      br_req  = 1'b0;
      br_drop = 0;
    end else if (!br_req && ($urandom_range(0, 99) < br_pct)) begin
      br_req = 1'b1;
      br_off = $urandom_range(0, 255);
    end
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (m_fetch) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_left = (wait_sel < 0) ? int'($urandom_range(0, 3)) : wait_sel;
      end
      if (mem_left == 0) begin
        imem_ack = 1'b1;
        mem_busy = 0;
        if (fixed) imem_rdata = data;
      end else begin
        mem_left--;
      end
    end
    #1;
    exp_adv = m_redir || (m_full && !br_req && dec_ready);
    chk("imem_req",    32'(imem_req),    32'(m_fetch));
    chk("imem_addr",   imem_addr,        m_fetch ? pc_m : 32'd0);
    chk("misalign",    32'(misalign),    32'(m_fetch && (pc_m[1:0] != 2'b00)));
    chk("instr_valid", 32'(instr_valid), 32'(m_full));
    chk("instr",       instr,            m_instr);
    chk("instr_pc",    instr_pc,         m_ipc);
    chk("br_ack",      32'(br_ack),      32'(m_redir));
    chk("take_branch", 32'(take_branch), 32'(m_redir));
    chk("pc_adv",      32'(pc_adv),      32'(exp_adv));
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt",   fetch_cnt,        m_fetched);
    chk("squash_cnt",  32'(squash_cnt),  32'(m_squashed));
`endif
    pc_old = pc_m;
    if (exp_adv) pc_m = m_redir ? pc_m + 32'd4 + br_off : pc_m + 32'd4;
    if (m_boot) begin
      m_boot  = 0;
      m_fetch = 1;
    end else if (m_fetch) begin
      if (br_req) m_pend = 1;
      if (imem_ack) begin
        m_fetched++;
        m_fetch = 0;
        if (m_pend) begin
          m_squashed++;
          m_redir = 1;
        end else begin
          m_full  = 1;
          m_instr = imem_rdata;
          m_ipc   = pc_old;
        end
      end
    end else if (m_full) begin
      if (br_req) begin
        m_full = 0;
        m_squashed++;
        m_redir = 1;
      end else if (dec_ready) begin
        m_full  = 0;
        m_fetch = 1;
      end
    end else if (m_redir) begin
      m_redir = 0;
      m_pend  = 0;
      m_fetch = 1;
      br_drop = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    int guard;
    rst = 1'b0; pc_in = '0; imem_ack = 1'b0; imem_rdata = '0;
    dec_ready = 1'b0; br_req = 1'b0;
    pc_m = '0; br_off = '0; mem_busy = 0; mem_left = 0; br_drop = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_imem_req",    32'(imem_req),    32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc_adv",      32'(pc_adv),      32'd0);
    chk("rst_take_branch", 32'(take_branch), 32'd0);
    chk("rst_br_ack",      32'(br_ack),      32'd0);
    chk("rst_misalign",    32'(misalign),    32'd0);
    chk("rst_imem_addr",   imem_addr,        32'd0);
    chk("rst_instr",       instr,            32'd0);
    chk("rst_instr_pc",    instr_pc,         32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Zero-wait memory, decode always ready, fixed first word.
    repeat (4)   do_cycle(0, 100, 0, 1, 32'h2001_0005);
    // Three memory wait cycles per fetch.
    repeat (12)  do_cycle(3, 100, 0, 0, '0);
    // Decode stalls.
    repeat (7)   do_cycle(0, 0, 0, 0, '0);
    repeat (3)   do_cycle(0, 100, 0, 0, '0);
    // Branches arriving during slow fetches.
    repeat (40)  do_cycle(3, 100, 100, 0, '0);
    // Branch competing with a ready decode in the slot.
    repeat (40)  do_cycle(0, 100, 50, 0, '0);
    // Mixed random traffic.
    repeat (2000) do_cycle(-1, 60, 10, 0, '0);

    // Asynchronous reset in the middle of a fetch.
    guard = 0;
    while (!m_fetch && guard < 20) begin
      do_cycle(3, 100, 0, 0, '0);
      guard++;
    end
    chk("reach_fetch", 32'(m_fetch), 32'd1);
    #1;
    chk("req_before_rst", 32'(imem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_imem_req",    32'(imem_req),    32'd0);
    chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("midrst_fetch_cnt",   fetch_cnt,        32'd0);
    chk("midrst_squash_cnt",  32'(squash_cnt),  32'd0);
`endif
    imem_ack = 1'b0; br_req = 1'b0; br_drop = 0; mem_busy = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (300) do_cycle(-1, 70, 15, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
